// File: rtl/nn_output_argmax.sv
// Output stage: latches the final-layer vector, scans it for the signed maximum
// and its index, pulses o_done, and serves the latched values for sequential readback.
`ifndef dataWidth
`define dataWidth 16
`endif

module nn_output_argmax #(
    parameter int NUM_INPUT  = 10,
    parameter int DATA_WIDTH = `dataWidth,
    parameter int IDX_WIDTH  = $clog2(NUM_INPUT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data,
    input  logic                          i_valid,
    output logic                          o_busy,
    output logic [31:0]                   o_idx,
    output logic [DATA_WIDTH-1:0]         o_max,
    output logic                          o_done,
    input  logic                          rd_req,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [1:0]                    dbg_state
);

    // Handshake: i_valid and rd_req are single-cycle strobes with no ready;
    // i_valid is taken only in IDLE and silently dropped otherwise, rd_req is always taken.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUT - 1);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] buf_q [NUM_INPUT];
    logic [DATA_WIDTH-1:0] cur_max;
    logic [IDX_WIDTH-1:0]  cur_idx;
    logic [IDX_WIDTH-1:0]  cnt;
    logic [IDX_WIDTH-1:0]  rd_ptr;
    logic [DATA_WIDTH-1:0] scan_elem;
    logic                  accept;

    assign scan_elem = buf_q[cnt];
    assign accept    = (state == ST_IDLE) && i_valid;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_max <= '0;
            cur_idx <= '0;
            cnt     <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_idx   <= '0;
            o_max   <= '0;
            rd_data <= '0;
            rd_ptr  <= '0;
            for (int k = 0; k < NUM_INPUT; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            // Registered from state so busy spans the first SCAN edge through the o_done cycle.
            o_busy <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        for (int k = 0; k < NUM_INPUT; k++) begin
                            buf_q[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        cur_max <= i_data[DATA_WIDTH-1:0];
                        cur_idx <= '0;
                        cnt     <= IDX_WIDTH'(1);
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if ($signed(scan_elem) > $signed(cur_max)) begin
                        cur_max <= scan_elem;
                        cur_idx <= cnt;
                    end
                    if (cnt == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + IDX_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b1;
                    o_idx  <= {{(32-IDX_WIDTH){1'b0}}, cur_idx};
                    o_max  <= cur_max;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A simultaneous accept restarts readback and returns the new element 0.
            if (accept) begin
                rd_ptr <= '0;
                if (rd_req) begin
                    rd_data <= i_data[DATA_WIDTH-1:0];
                end
            end else if (rd_req) begin
                rd_data <= buf_q[rd_ptr];
                rd_ptr  <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_nn_output_argmax.sv
// Directed bench for nn_output_argmax: argmax results, latency, busy window,
// busy guard, readback with wrap, accept/read collision and mid-scan reset.
module tb_nn_output_argmax;

    localparam int N  = 10;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] i_data;
    logic            i_valid;
    logic            o_busy;
    logic [31:0]     o_idx;
    logic [DW-1:0]   o_max;
    logic            o_done;
    logic            rd_req;
    logic [DW-1:0]   rd_data;
    logic [1:0]      dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] ev [N];
    logic [DW-1:0] alt [N];
    logic [DW-1:0] exp_rd [N];

    nn_output_argmax #(.NUM_INPUT(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_busy(o_busy), .o_idx(o_idx), .o_max(o_max), .o_done(o_done),
        .rd_req(rd_req), .rd_data(rd_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] a [N]);
        logic [N*DW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = a[k];
        return v;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge one cycle after o_done.
    task automatic run_vec(input string tag, input logic [N*DW-1:0] v, input int exp_idx,
                           input logic [DW-1:0] exp_max, input bit inject,
                           input logic [N*DW-1:0] v_alt, input bit with_rd,
                           input logic [DW-1:0] exp_rd0);
        int  lat;
        int  busy_cnt;
        bit  seen;
        i_data  = v;
        i_valid = 1'b1;
        rd_req  = with_rd;
        tick();
        i_valid  = 1'b0;
        rd_req   = 1'b0;
        lat      = 0;
        busy_cnt = int'(o_busy);
        seen     = 1'b0;
        if (with_rd) chk({tag, "_rd_collide"}, 32'(rd_data), 32'(exp_rd0));
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (inject && c == 4) begin
                i_data  = v_alt;
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            lat = c;
            if (o_busy) busy_cnt++;
            if (o_done) seen = 1'b1;
        end
        i_valid = 1'b0;
        chk({tag, "_latency"}, 32'(seen ? lat : -1), 32'd10);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd10);
        chk({tag, "_idx"}, o_idx, 32'(exp_idx));
        chk({tag, "_max"}, 32'(o_max), 32'(exp_max));
        tick();
        chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_idx_hold"}, o_idx, 32'(exp_idx));
    endtask

    initial begin
        int done_cnt;
        rst     = 1'b1;
        i_valid = 1'b0;
        rd_req  = 1'b0;
        i_data  = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_idx", o_idx, 32'd0);
        chk("rst_max", 32'(o_max), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        tick();

        // Distinct values
        ev = '{16'h0003, 16'hFFFF, 16'h0007, 16'h0002, 16'h0000,
               16'h0005, 16'hFFF8, 16'h0001, 16'h0006, 16'h0004};
        exp_rd = ev;
        run_vec("distinct", pack(ev), 2, 16'h0007, 1'b0, '0, 1'b0, '0);

        // Readback with wrap: 12 requests back to back
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) chk($sformatf("readback_%0d", i - 1), 32'(rd_data), 32'(exp_rd[(i-1) % N]));
            rd_req = (i < 12);
            tick();
        end
        rd_req = 1'b0;

        // All equal negatives, with a read colliding with the accept
        for (int k = 0; k < N; k++) ev[k] = 16'hFFF0;
        run_vec("tie_neg", pack(ev), 0, 16'hFFF0, 1'b0, '0, 1'b1, 16'hFFF0);

        for (int k = 0; k < N; k++) ev[k] = 16'h0000;
        ev[4] = 16'h0100;
        ev[9] = 16'h0100;
        run_vec("tie_pos", pack(ev), 4, 16'h0100, 1'b0, '0, 1'b0, '0);

        for (int k = 0; k < N; k++) ev[k] = 16'h0000;
        ev[0] = 16'h7FFF;
        ev[1] = 16'h8000;
        run_vec("signed", pack(ev), 0, 16'h7FFF, 1'b0, '0, 1'b0, '0);

        // Busy guard: intruding vector mid-scan must be ignored
        for (int k = 0; k < N; k++) begin
            ev[k]  = 16'h0010;
            alt[k] = 16'h0000;
        end
        ev[6]  = 16'h0042;
        alt[1] = 16'h7000;
        run_vec("guard", pack(ev), 6, 16'h0042, 1'b1, pack(alt), 1'b0, '0);

        // Accepted on the cycle after o_done
        for (int k = 0; k < N; k++) ev[k] = 16'hFFFE;
        ev[9] = 16'h0123;
        run_vec("last_max", pack(ev), 9, 16'h0123, 1'b0, '0, 1'b0, '0);

        // Reset mid-scan
        i_data  = pack(exp_rd);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        chk("mid_rst_idx", o_idx, 32'd0);
        chk("mid_rst_max", 32'(o_max), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (o_done) done_cnt++;
        end
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("mid_rst_buf_clear", 32'(rd_data), 32'd0);
        tick();

        for (int k = 0; k < N; k++) ev[k] = 16'h0000;
        ev[4] = 16'h0100;
        ev[9] = 16'h0100;
        run_vec("after_rst", pack(ev), 4, 16'h0100, 1'b0, '0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_output_argmax.md
# nn_output_argmax

Output-side stage for `nn_autoGen_top` that consumes the final layer's parallel output vector. It latches the vector, scans it sequentially to find the signed maximum and its index, and raises a one-cycle completion pulse that drives the top-level `intr`. It also holds the latched outputs for sequential readback through the AXI-lite register file: the detected class is read from offset 8, and per-neuron outputs from offset 20, one value per read.

## Interface
Parameters:
- `NUM_INPUT`, 10: neurons in the final layer. Must be ≥ 2.
- `DATA_WIDTH`, `` `dataWidth `` (16): width of each neuron output, two's-complement.
- `IDX_WIDTH`, `$clog2(NUM_INPUT)`: internal index/counter width.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i_data` in `NUM_INPUT*DATA_WIDTH`: final-layer outputs. Element k is `i_data[k*DATA_WIDTH +: DATA_WIDTH]`.
- `i_valid` in 1: one-cycle strobe; `i_data` is valid this cycle.
- `o_busy` out 1: high while a scan is in progress, i.e. from the cycle after accept through the cycle of `o_done`.
- `o_idx` out 32: index of the maximum, zero-extended. Updated only at `o_done`.
- `o_max` out `DATA_WIDTH`: the maximum value. Updated only at `o_done`.
- `o_done` out 1: one-cycle pulse when the result is valid. Drives `intr`.
- `rd_req` in 1: one-cycle pop strobe from the AXI read decode (offset 20).
- `rd_data` out `DATA_WIDTH`: latched element addressed by the read pointer. Registered.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, when `i_valid` = 1:
  - Latch `i_data` into the buffer.
  - `cur_max` ← element 0; `cur_idx` ← 0; `cnt` ← 1.
  - Reset the read pointer `rd_ptr` to 0.
  - Next state SCAN.
- SCAN, each cycle:
  - Compare element[`cnt`] with `cur_max` as signed values, using strict greater-than.
  - If greater: `cur_max` ← element[`cnt`] and `cur_idx` ← `cnt`.
  - If `cnt` = NUM_INPUT-1: go to DONE. Otherwise `cnt` ← `cnt`+1.
- DONE, one cycle:
  - `o_done` = 1; `o_idx` ← `cur_idx`; `o_max` ← `cur_max`.
  - Next state IDLE.
- Ties: the lowest index wins. This follows from the strict comparison.
- `i_valid` while in SCAN or DONE is ignored. The buffer is not modified and no error is flagged. The producer (the layer controller) guarantees spacing between vectors.
- `o_idx` and `o_max` hold their values until the next DONE. They must be readable any number of times.
- Readback:
  - On `rd_req` = 1, `rd_data` ← buffer[`rd_ptr`] on the next edge, and `rd_ptr` increments.
  - `rd_ptr` wraps from NUM_INPUT-1 to 0.
  - `rd_req` is legal in any state. It always reads the most recently latched vector.
- Simultaneous `i_valid` (accepted in IDLE) and `rd_req`: the accept wins. `rd_ptr` ← 0, and `rd_data` returns element 0 of the new vector.

## Timing
- Reset values: state IDLE; `o_busy`=0; `o_done`=0; `o_idx`=0; `o_max`=0; `rd_data`=0; `rd_ptr`=0; buffer cleared to 0.
- Latency: accept at edge T0 (`i_valid` sampled high in IDLE). SCAN occupies edges T1 through T(NUM_INPUT-1). `o_done`, `o_idx` and `o_max` are valid in the cycle after edge T(NUM_INPUT).
  - For NUM_INPUT=10: 10 cycles from `i_valid` to `o_done`.
- Earliest next accept is the cycle after `o_done`, giving a throughput of one vector per NUM_INPUT+1 cycles.
- `rd_data` latency is 1 cycle after `rd_req`. Back-to-back `rd_req` is supported at 1 per cycle.
- Reset asserted mid-SCAN: return to IDLE next edge. No `o_done` is produced. `o_idx` and `o_max` are zeroed.
- No combinational path from any input to any output.

## Test plan
- **Distinct values:** N=10, elements {3,-1,7,2,0,5,-8,1,6,4} (hex 16-bit). Pulse `i_valid` → `o_done` exactly 10 cycles later, `o_idx`=2, `o_max`=7, `o_busy` high for 10 cycles.
- **Ties and negatives:** all elements = 0xFFF0 (-16) → `o_idx`=0, `o_max`=0xFFF0. Then elements 4 and 9 = 0x0100, rest 0 → `o_idx`=4.
- **Signed comparison:** element 0 = 0x7FFF, element 1 = 0x8000 → `o_idx`=0, i.e. 0x8000 is treated as negative. Last element as unique max → `o_idx`=9.
- **Busy guard:** a second `i_valid` with a different vector at cycle 4 of a scan is ignored. The result matches the first vector. A new `i_valid` the cycle after `o_done` is accepted, and its result appears 10 cycles later.
- **Readback:** after the first test, 12 consecutive `rd_req` → `rd_data` = 3,-1,7,2,0,5,-8,1,6,4,3,-1, each 1 cycle after its request (wrap verified). `rd_req` together with `i_valid` in IDLE → `rd_data` = new element 0.
- **Reset mid-scan:** `rst`=1 at cycle 5 of a scan → no `o_done`. All outputs 0 the next cycle. A subsequent vector is processed normally.
